// File: rtl/win_scanner.sv
// win_scanner: sequential four-in-a-row detector for a 6x7 board.
// Snapshots the board on request and checks one anchor cell per cycle in
// row-major order, reporting the first winning line and its direction.
// Optional feature macro: WIN_SCAN_AUTO_EN (auto-start on board change).
module win_scanner (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [5:0][6:0][1:0] panel,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 win_a,
   output logic                 win_b,
   output logic                 on_the_same_row,
   output logic                 on_the_same_column,
   output logic                 diagonal_l_to_r,
   output logic                 diagonal_r_to_l,
   output logic [2:0]           i_win,
   output logic [2:0]           j_win
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_WON = 2'd2} state_t;

   state_t               state_q, state_d;
   logic [5:0]           idx_q, idx_d;
   logic [5:0][6:0][1:0] snap_q, snap_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 win_a_q, win_a_d;
   logic                 win_b_q, win_b_d;
   logic [3:0]           dir_q, dir_d;     // {row, column, l_to_r, r_to_l}
   logic [2:0]           i_q, i_d;
   logic [2:0]           j_q, j_d;

   logic                 trig;
   logic [2:0]           ai, aj;
   logic [1:0]           own_row, own_col, own_lr, own_rl;
   logic                 hit;
   logic [1:0]           hit_own;
   logic [3:0]           hit_dir;

   // Off-board coordinates read as empty so a line running off the edge never wins.
   function automatic logic [1:0] cell_at(input logic [5:0][6:0][1:0] b,
                                          input int r, input int c);
      logic [2:0] rr;
      logic [2:0] cc;
      rr = r[2:0];
      cc = c[2:0];
      if (r < 0 || r > 5 || c < 0 || c > 6) return 2'd0;
      return b[rr][cc];
   endfunction

   // Owner code (1 or 2) when all four cells of the line match, else 0.
   function automatic logic [1:0] line_owner(input logic [5:0][6:0][1:0] b,
                                             input int i, input int j,
                                             input int di, input int dj);
      logic [1:0] c0;
      logic       same;
      c0   = cell_at(b, i, j);
      same = 1'b1;
      for (int k = 1; k < 4; k++) begin
         if (cell_at(b, i + k * di, j + k * dj) != c0) same = 1'b0;
      end
      if (same && (c0 == 2'd1 || c0 == 2'd2)) return c0;
      return 2'd0;
   endfunction

`ifdef WIN_SCAN_AUTO_EN
   // A board that differs from the last snapshot also requests a scan.
   assign trig = start | (panel != snap_q);
`else
   assign trig = start;
`endif

   assign ai = 3'(idx_q / 6'd7);
   assign aj = 3'(idx_q % 6'd7);

   // Evaluate the four candidate lines at the current anchor, skipping ones that do not fit.
   always_comb begin
      own_row = 2'd0;
      own_col = 2'd0;
      own_lr  = 2'd0;
      own_rl  = 2'd0;
      if (aj <= 3'd3)                own_row = line_owner(snap_q, int'(ai), int'(aj), 0, 1);
      if (ai <= 3'd2)                own_col = line_owner(snap_q, int'(ai), int'(aj), 1, 0);
      if (ai <= 3'd2 && aj <= 3'd3)  own_lr  = line_owner(snap_q, int'(ai), int'(aj), 1, 1);
      if (ai <= 3'd2 && aj >= 3'd3)  own_rl  = line_owner(snap_q, int'(ai), int'(aj), 1, -1);
   end

   // Pick one winning direction: row beats column beats l_to_r beats r_to_l.
   always_comb begin
      hit     = 1'b0;
      hit_own = 2'd0;
      hit_dir = 4'b0000;
      if (own_row != 2'd0) begin
         hit = 1'b1; hit_own = own_row; hit_dir = 4'b1000;
      end else if (own_col != 2'd0) begin
         hit = 1'b1; hit_own = own_col; hit_dir = 4'b0100;
      end else if (own_lr != 2'd0) begin
         hit = 1'b1; hit_own = own_lr;  hit_dir = 4'b0010;
      end else if (own_rl != 2'd0) begin
         hit = 1'b1; hit_own = own_rl;  hit_dir = 4'b0001;
      end
   end

   // Next-state logic: WON is terminal until reset.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (trig) state_d = S_SCAN;
         S_SCAN: begin
            if (hit)                   state_d = S_WON;
            else if (idx_q == 6'd41)   state_d = S_IDLE;
         end
         S_WON:   state_d = S_WON;
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values; everything holds except the done pulse.
   always_comb begin
      busy_d  = busy_q;
      done_d  = 1'b0;
      win_a_d = win_a_q;
      win_b_d = win_b_q;
      dir_d   = dir_q;
      i_d     = i_q;
      j_d     = j_q;
      idx_d   = idx_q;
      snap_d  = snap_q;
      case (state_q)
         S_IDLE: begin
            if (trig) begin
               snap_d = panel;
               idx_d  = 6'd0;
               busy_d = 1'b1;
            end
         end
         S_SCAN: begin
            if (hit) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               win_a_d = (hit_own == 2'd1);
               win_b_d = (hit_own == 2'd2);
               dir_d   = hit_dir;
               i_d     = ai;
               j_d     = aj;
            end else begin
               idx_d = idx_q + 6'd1;
               if (idx_q == 6'd41) begin
                  busy_d = 1'b0;
                  done_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // State, control and result registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= 6'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         win_a_q <= 1'b0;
         win_b_q <= 1'b0;
         dir_q   <= 4'b0000;
         i_q     <= 3'd0;
         j_q     <= 3'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         win_a_q <= win_a_d;
         win_b_q <= win_b_d;
         dir_q   <= dir_d;
         i_q     <= i_d;
         j_q     <= j_d;
      end
   end

`ifdef WIN_SCAN_AUTO_EN
   // Snapshot register; starts all-empty so the first board change triggers a scan.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) snap_q <= '0;
      else      snap_q <= snap_d;
   end
`else
   // Snapshot register; only meaningful once a scan has been requested.
   always_ff @(posedge clk) begin
      snap_q <= snap_d;
   end
`endif

   assign busy               = busy_q;
   assign done               = done_q;
   assign win_a              = win_a_q;
   assign win_b              = win_b_q;
   assign on_the_same_row    = dir_q[3];
   assign on_the_same_column = dir_q[2];
   assign diagonal_l_to_r    = dir_q[1];
   assign diagonal_r_to_l    = dir_q[0];
   assign i_win              = i_q;
   assign j_win              = j_q;

endmodule

// File: doc/win_scanner.md
# win_scanner

Sequential four-in-a-row detector that sits directly upstream of the game-control FSM. On request it snapshots the 6x7 board, then scans every anchor cell in a fixed order. It reports the first winning line as a winner flag, a direction flag and anchor coordinates (i_win, j_win). The FSM uses these to highlight the four winning cells.

## Interface
Parameters: none; the board geometry is fixed at 6 rows x 7 columns, 2 bits per cell.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- panel  in  [5:0][6:0][1:0]  board; row 0 top, row 5 bottom; cell codes: 0 empty, 1 player A, 2 player B, 3 highlighted
- start  in  1  scan request, sampled in IDLE only
- busy  out  1  high while scanning
- done  out  1  one-cycle pulse when a scan ends, with or without a win
- win_a / win_b  out  1  sticky winner flags
- on_the_same_row, on_the_same_column, diagonal_l_to_r, diagonal_r_to_l  out  1 each  sticky one-hot direction of the winning line
- i_win, j_win  out  3 each  anchor row and column of the winning line

## Operation
- States: IDLE, SCAN, WON. Reset enters IDLE. All outputs and the anchor counter reset to 0.
- IDLE, start=1:
  - Copy panel into an 84-bit snapshot.
  - Clear the 6-bit anchor index to 0.
  - Set busy and go to SCAN.
- SCAN checks one anchor per cycle, using the snapshot only. Live panel changes during a scan are ignored.
- Anchor index k maps to i=k/7, j=k%7. Order is row-major, k=0..41.
- Lines tested at each anchor (i,j), with k=0..3; a direction is only tested if it fits on the board:
  - row: (i, j+k), requires j≤3
  - column: (i+k, j), requires i≤2
  - diagonal_l_to_r: (i+k, j+k), requires i≤2 and j≤3
  - diagonal_r_to_l: (i+k, j-k), requires i≤2 and j≥3
- A line wins if all four cells equal 1 (win_a) or all four equal 2 (win_b). A code-3 cell never counts toward a line.
- If several directions win at the same anchor, priority is row > column > diagonal_l_to_r > diagonal_r_to_l. Exactly one direction flag is set.
- On a win:
  - Register the winner flag, the direction flag, and i_win/j_win = anchor.
  - Pulse done, drop busy, go to WON.
- After anchor 41 with no win: pulse done, drop busy, go to IDLE. Flags stay 0.
- WON holds every output (done excepted) until reset. start is ignored in WON, so the FSM's later writes of code 3 cannot clear the result.
- start while busy is ignored and is not queued.
- Reset asserted mid-scan aborts immediately and returns all outputs to 0.

## Timing
- Edge 0: start sampled in IDLE; snapshot taken; busy=1 after edge 0.
- Anchor k is evaluated combinationally during the cycle after edge k.
- The result for anchor k is registered at edge k+1:
  - Flags and done are visible after that edge.
  - busy falls at the same edge.
- Worst case (no win): done after edge 42, busy high for 42 cycles.
- Back-to-back scans: start may be reasserted in the cycle in which done is high. It is accepted if the block is in IDLE, i.e. only after a no-win scan.

## Configuration
- Macro WIN_SCAN_AUTO_EN.
- Defined:
  - In IDLE, the block also starts a scan when panel differs from the last snapshot. This is an internal compare, and the trigger is OR-ed with start.
  - Snapshot and first-scan state reset to all-empty.
- Undefined: scans start only on start=1, and the compare logic is absent.
- Identical in both cases: cycle timing, WON behaviour, start handling.

## Test plan
- Empty board, start pulse → busy for 42 cycles, done after edge 42, all flags 0, block back in IDLE.
- Player A at (5,2..5), start → at edge 38: win_a=1, on_the_same_row=1, i_win=5, j_win=2, done=1, busy=0.
- Player B at (2..5,0), start → at edge 15: win_b=1, on_the_same_column=1, i_win=2, j_win=0. A second start and a panel change with every cell set to 3 → outputs unchanged (WON).
- Player A at (2,6),(3,5),(4,4),(5,3), start → diagonal_r_to_l=1, i_win=2, j_win=6, done at edge 21. Also: (0,0),(1,1),(2,2),(3,3) = 1,1,1,3 → no win.
- Start while busy, then panel modified at edge 5 to form a row → ignored, scan completes with no win. Reset low at edge 10 → all outputs 0 immediately, block in IDLE.
- With WIN_SCAN_AUTO_EN defined, start held 0, a single cell set to 1 → scan begins on the next edge and done arrives 42 cycles later. Without the macro → no activity.
